// File: rtl/alu_dispatch_if.sv
// Handshake and operand bus between register-file read, the dispatch stage and the ALU.
// The slave modport is the dispatch stage's view; master is the surrounding pipeline's view.
interface alu_dispatch_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_op1;
    logic [WIDTH-1:0] alu_op2;
    logic [3:0]       alu_ctrl;
    logic [4:0]       rd;
    logic             wb_en;
    logic             illegal;

    modport master (
        output flush, in_valid, inst, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, alu_op1, alu_op2, alu_ctrl, rd, wb_en, illegal
    );

    modport slave (
        input  flush, in_valid, inst, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, alu_op1, alu_op2, alu_ctrl, rd, wb_en, illegal
    );
endinterface

// File: rtl/alu_dispatch.sv
// RV32I integer-ALU decode/issue stage: decodes the instruction into ALU operands and
// control, and holds the result in a single-entry valid/ready buffer with synchronous flush.
module alu_dispatch #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_dispatch_if.slave bus
);

    typedef enum logic [3:0] {
        CTRL_ADD  = 4'b0000,
        CTRL_SUB  = 4'b0001,
        CTRL_EQ   = 4'b0010,
        CTRL_LTU  = 4'b0011,
        CTRL_LT   = 4'b0100,
        CTRL_AND  = 4'b0101,
        CTRL_OR   = 4'b0110,
        CTRL_XOR  = 4'b0111,
        CTRL_SRL  = 4'b1000,
        CTRL_SLL  = 4'b1001,
        CTRL_NONE = 4'b1111
    } alu_ctrl_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    generate
        if (WIDTH != 32) begin : g_bad_width
            $error("alu_dispatch decodes RV32I only; WIDTH must be 32");
        end
    endgenerate

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = bus.inst[6:0];
    assign funct3 = bus.inst[14:12];
    assign funct7 = bus.inst[31:25];

    logic [WIDTH-1:0] imm_i;
    logic [WIDTH-1:0] imm_u;
    logic [WIDTH-1:0] imm_shamt;

    assign imm_i     = {{(WIDTH-12){bus.inst[31]}}, bus.inst[31:20]};
    assign imm_u     = {bus.inst[31:12], 12'b0};
    assign imm_shamt = {{(WIDTH-5){1'b0}}, bus.inst[24:20]};

    alu_ctrl_e        dec_ctrl;
    logic             dec_illegal;
    logic [WIDTH-1:0] dec_op1;
    logic [WIDTH-1:0] dec_op2;
    logic             dec_wb_en;

    // Decode; anything not matched stays illegal with the ALU idled and zero operands.
    always_comb begin
        dec_ctrl    = CTRL_NONE;
        dec_illegal = 1'b1;
        dec_op1     = '0;
        dec_op2     = '0;

        case (opcode)
            OPC_OP: begin
                dec_op1 = bus.rs1_data;
                dec_op2 = bus.rs2_data;
                if (funct7 == F7_BASE) begin
                    dec_illegal = 1'b0;
                    case (funct3)
                        3'b000:  dec_ctrl = CTRL_ADD;
                        3'b001:  dec_ctrl = CTRL_SLL;
                        3'b010:  dec_ctrl = CTRL_LT;
                        3'b011:  dec_ctrl = CTRL_LTU;
                        3'b100:  dec_ctrl = CTRL_XOR;
                        3'b101:  dec_ctrl = CTRL_SRL;
                        3'b110:  dec_ctrl = CTRL_OR;
                        default: dec_ctrl = CTRL_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_illegal = 1'b0;
                    dec_ctrl    = CTRL_SUB;
                end
            end
            OPC_OP_IMM: begin
                dec_op1 = bus.rs1_data;
                dec_op2 = imm_i;
                case (funct3)
                    3'b000: begin
                        dec_illegal = 1'b0;
                        dec_ctrl    = CTRL_ADD;
                    end
                    3'b010: begin
                        dec_illegal = 1'b0;
                        dec_ctrl    = CTRL_LT;
                    end
                    3'b011: begin
                        dec_illegal = 1'b0;
                        dec_ctrl    = CTRL_LTU;
                    end
                    3'b100: begin
                        dec_illegal = 1'b0;
                        dec_ctrl    = CTRL_XOR;
                    end
                    3'b110: begin
                        dec_illegal = 1'b0;
                        dec_ctrl    = CTRL_OR;
                    end
                    3'b111: begin
                        dec_illegal = 1'b0;
                        dec_ctrl    = CTRL_AND;
                    end
                    3'b001: begin
                        dec_op2 = imm_shamt;
                        if (funct7 == F7_BASE) begin
                            dec_illegal = 1'b0;
                            dec_ctrl    = CTRL_SLL;
                        end
                    end
                    default: begin
                        dec_op2 = imm_shamt;
                        if (funct7 == F7_BASE) begin
                            dec_illegal = 1'b0;
                            dec_ctrl    = CTRL_SRL;
                        end
                    end
                endcase
            end
            OPC_LUI: begin
                dec_illegal = 1'b0;
                dec_ctrl    = CTRL_ADD;
                dec_op1     = '0;
                dec_op2     = imm_u;
            end
            OPC_AUIPC: begin
                dec_illegal = 1'b0;
                dec_ctrl    = CTRL_ADD;
                dec_op1     = bus.pc;
                dec_op2     = imm_u;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase

        // The ALU shifts by its full second operand, so only the low five bits may survive.
        if (dec_illegal) begin
            dec_ctrl = CTRL_NONE;
            dec_op1  = '0;
            dec_op2  = '0;
        end else if (dec_ctrl == CTRL_SLL || dec_ctrl == CTRL_SRL) begin
            dec_op2 = {{(WIDTH-5){1'b0}}, dec_op2[4:0]};
        end
    end

    assign dec_wb_en = !dec_illegal && (bus.inst[11:7] != 5'd0);

    logic             out_valid_q;
    logic [WIDTH-1:0] alu_op1_q;
    logic [WIDTH-1:0] alu_op2_q;
    logic [3:0]       alu_ctrl_q;
    logic [4:0]       rd_q;
    logic             wb_en_q;
    logic             illegal_q;
    logic             accept;

    assign bus.in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Single-entry buffer: reset beats flush beats transfer; data holds unless a new entry loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
            alu_ctrl_q  <= CTRL_ADD;
            rd_q        <= 5'd0;
            wb_en_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            alu_op1_q   <= dec_op1;
            alu_op2_q   <= dec_op2;
            alu_ctrl_q  <= dec_ctrl;
            rd_q        <= bus.inst[11:7];
            wb_en_q     <= dec_wb_en;
            illegal_q   <= dec_illegal;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.alu_op1   = alu_op1_q;
    assign bus.alu_op2   = alu_op2_q;
    assign bus.alu_ctrl  = alu_ctrl_q;
    assign bus.rd        = rd_q;
    assign bus.wb_en     = wb_en_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: directed decode cases, backpressure, flush, reset,
// then randomized traffic against a mnemonic-level reference model.
module tb_alu_dispatch;

    logic clk = 1'b0;
    logic rst;

    alu_dispatch_if #(.WIDTH(32)) bus ();

    alu_dispatch #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
    } out_t;

    int   checks = 0;
    int   errors = 0;
    logic m_valid = 1'b0;
    out_t m_data  = '0;

    function automatic out_t sample();
        out_t o;
        o.valid = bus.out_valid;
        o.op1   = bus.alu_op1;
        o.op2   = bus.alu_op2;
        o.ctrl  = bus.alu_ctrl;
        o.rd    = bus.rd;
        o.wb    = bus.wb_en;
        o.ill   = bus.illegal;
        return o;
    endfunction

    function automatic out_t mk(logic [31:0] op1, logic [31:0] op2, logic [3:0] ctrl,
                                logic [4:0] rd, logic wb, logic ill);
        out_t o;
        o.valid = 1'b1;
        o.op1   = op1;
        o.op2   = op2;
        o.ctrl  = ctrl;
        o.rd    = rd;
        o.wb    = wb;
        o.ill   = ill;
        return o;
    endfunction

    // Reference: name the instruction first, then derive operands and ALU code from the name.
    function automatic out_t ref_decode(logic [31:0] inst, logic [31:0] pc,
                                        logic [31:0] rs1, logic [31:0] rs2);
        string       mn;
        out_t        o;
        int unsigned opc, f3, f7;
        logic [31:0] imm_i, imm_u;
        opc   = inst & 32'h7F;
        f3    = (inst >> 12) & 7;
        f7    = inst >> 25;
        imm_i = 32'($signed(inst) >>> 20);
        imm_u = inst & 32'hFFFFF000;
        mn    = "illegal";
        if (opc == 'h33 && f7 == 0) begin
            case (f3)
                0: mn = "add";  1: mn = "sll";  2: mn = "slt"; 3: mn = "sltu";
                4: mn = "xor";  5: mn = "srl";  6: mn = "or";  default: mn = "and";
            endcase
        end else if (opc == 'h33 && f7 == 'h20 && f3 == 0) begin
            mn = "sub";
        end else if (opc == 'h13) begin
            case (f3)
                0: mn = "addi"; 2: mn = "slti"; 3: mn = "sltiu"; 4: mn = "xori";
                6: mn = "ori";  7: mn = "andi";
                1: if (f7 == 0) mn = "slli";
                default: if (f7 == 0) mn = "srli";
            endcase
        end else if (opc == 'h37) begin
            mn = "lui";
        end else if (opc == 'h17) begin
            mn = "auipc";
        end
        o       = '0;
        o.valid = 1'b1;
        o.rd    = inst[11:7];
        case (mn)
            "add":   begin o.ctrl = 4'd0; o.op1 = rs1; o.op2 = rs2; end
            "sub":   begin o.ctrl = 4'd1; o.op1 = rs1; o.op2 = rs2; end
            "sll":   begin o.ctrl = 4'd9; o.op1 = rs1; o.op2 = rs2 % 32; end
            "slt":   begin o.ctrl = 4'd4; o.op1 = rs1; o.op2 = rs2; end
            "sltu":  begin o.ctrl = 4'd3; o.op1 = rs1; o.op2 = rs2; end
            "xor":   begin o.ctrl = 4'd7; o.op1 = rs1; o.op2 = rs2; end
            "srl":   begin o.ctrl = 4'd8; o.op1 = rs1; o.op2 = rs2 % 32; end
            "or":    begin o.ctrl = 4'd6; o.op1 = rs1; o.op2 = rs2; end
            "and":   begin o.ctrl = 4'd5; o.op1 = rs1; o.op2 = rs2; end
            "addi":  begin o.ctrl = 4'd0; o.op1 = rs1; o.op2 = imm_i; end
            "slti":  begin o.ctrl = 4'd4; o.op1 = rs1; o.op2 = imm_i; end
            "sltiu": begin o.ctrl = 4'd3; o.op1 = rs1; o.op2 = imm_i; end
            "xori":  begin o.ctrl = 4'd7; o.op1 = rs1; o.op2 = imm_i; end
            "ori":   begin o.ctrl = 4'd6; o.op1 = rs1; o.op2 = imm_i; end
            "andi":  begin o.ctrl = 4'd5; o.op1 = rs1; o.op2 = imm_i; end
            "slli":  begin o.ctrl = 4'd9; o.op1 = rs1; o.op2 = imm_i % 32; end
            "srli":  begin o.ctrl = 4'd8; o.op1 = rs1; o.op2 = imm_i % 32; end
            "lui":   begin o.ctrl = 4'd0; o.op1 = 0;   o.op2 = imm_u; end
            "auipc": begin o.ctrl = 4'd0; o.op1 = pc;  o.op2 = imm_u; end
            default: begin o.ctrl = 4'hF; o.ill = 1'b1; end
        endcase
        o.wb = !o.ill && (o.rd != 0);
        return o;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  opc, f7;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 9);
        opc = (k < 4) ? 7'h33 : (k < 7) ? 7'h13 : (k == 7) ? 7'h37 : (k == 8) ? 7'h17 : r[6:0];
        k = $urandom_range(0, 9);
        f7 = (k < 6) ? 7'h00 : (k < 9) ? 7'h20 : r[31:25];
        if (opc == 7'h37 || opc == 7'h17) f7 = r[31:25];
        return {f7, r[24:7], opc};
    endfunction

    task automatic drive(logic valid, logic [31:0] inst, logic [31:0] pc,
                         logic [31:0] rs1, logic [31:0] rs2);
        bus.in_valid = valid;
        bus.inst     = inst;
        bus.pc       = pc;
        bus.rs1_data = rs1;
        bus.rs2_data = rs2;
    endtask

    task automatic tick();
        logic rdy;
        rdy = !bus.flush && (!m_valid || bus.out_ready);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
        end else if (bus.flush) begin
            m_valid = 1'b0;
        end else if (bus.in_valid && rdy) begin
            m_data  = ref_decode(bus.inst, bus.pc, bus.rs1_data, bus.rs2_data);
            m_valid = 1'b1;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_t obs;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        obs = sample();
        checks++;
        if (obs !== out_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_state got %h required %h", obs, out_t'(0));
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_decode();
        out_t obs;
        out_t exp_tab [6];
        logic [31:0] inst_tab [6];
        logic [31:0] pc_tab [6];
        logic [31:0] rs1_tab [6];
        logic [31:0] rs2_tab [6];
        inst_tab = '{32'h002081B3, 32'h007312B3, 32'hFFF00093, 32'h123450B7, 32'h12345097, 32'h4010D093};
        pc_tab   = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104};
        rs1_tab  = '{32'd5, 32'h11, 32'h0, 32'hDEAD, 32'hBEEF, 32'h55};
        rs2_tab  = '{32'd7, 32'h23, 32'h9, 32'h1234, 32'h77, 32'h66};
        exp_tab  = '{mk(32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0),
                     mk(32'h11, 32'h3, 4'b1001, 5'd5, 1'b1, 1'b0),
                     mk(32'h0, 32'hFFFFFFFF, 4'b0000, 5'd1, 1'b1, 1'b0),
                     mk(32'h0, 32'h12345000, 4'b0000, 5'd1, 1'b1, 1'b0),
                     mk(32'h100, 32'h12345000, 4'b0000, 5'd1, 1'b1, 1'b0),
                     mk(32'h0, 32'h0, 4'b1111, 5'd1, 1'b0, 1'b1)};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, inst_tab[i], pc_tab[i], rs1_tab[i], rs2_tab[i]);
            tick();
            obs = sample();
            checks++;
            if (obs !== exp_tab[i]) begin
                errors++;
                $display("[TB] FAIL decode_%0d got %h required %h", i, obs, exp_tab[i]);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL consume_drain got out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_t obs, held;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h002081B3, 32'h0, 32'd10, 32'd20);
        tick();
        held = sample();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h40208133, 32'h4, 32'd30, 32'd40);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_in_ready_%0d got %b required 0", i, bus.in_ready);
            end
            tick();
            obs = sample();
            checks++;
            if (obs !== held || obs.valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d got %h required %h", i, obs, held);
            end
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive(1'b1, rand_inst(), $urandom, $urandom, $urandom);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_in_ready_%0d got %b required 1", i, bus.in_ready);
            end
            tick();
            obs = sample();
            checks++;
            if (obs !== m_data || obs.valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_data_%0d got %h required %h", i, obs, m_data);
            end
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h00A00513, 32'h0, 32'h0, 32'h0);
        tick();
        bus.out_ready = 1'b0;
        bus.flush = 1'b1;
        drive(1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd2);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_in_ready got %b required 0", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_kill got out_valid=%b required 0", bus.out_valid);
        end
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_drop got out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        out_t obs;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0062E233, 32'h0, 32'h1234, 32'h5678);
        tick();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs = sample();
        checks++;
        if (obs !== out_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_mid_stall got %h required %h", obs, out_t'(0));
        end
    endtask

    task automatic test_random();
        out_t obs;
        logic exp_rdy;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            bus.flush = ($urandom_range(0, 15) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom, $urandom);
            #1;
            exp_rdy = !bus.flush && (!m_valid || bus.out_ready);
            checks++;
            if (bus.in_ready !== exp_rdy) begin
                errors++;
                $display("[TB] FAIL rand_in_ready_%0d got %b required %b", i, bus.in_ready, exp_rdy);
            end
            tick();
            obs = sample();
            checks++;
            if (m_valid ? (obs !== m_data) : (obs.valid !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL rand_out_%0d got %h required %h (valid=%b)", i, obs, m_data, m_valid);
            end
        end
        rst = 1'b0;
        bus.flush = 1'b0;
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
Decode/issue pipeline stage that drives the ALU's operand and control inputs: it decodes RV32I integer-ALU instructions into {alu_op1, alu_op2, alu_ctrl} using the ALU's 4-bit operation encoding. It registers the result into a single-entry ID/EX-style buffer with valid/ready handshakes on both sides, plus a synchronous flush. It sits between the register-file read and the ALU in the pipelined core.

Parameters:
WIDTH, 32, datapath width of operands and PC. Decoding is RV32I-specific; the only legal value is 32.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous kill of buffered entry and of same-cycle input
in_valid  input  1  upstream has instruction + operands
in_ready  output  1  stage can accept this cycle
inst  input  32  raw instruction word
pc  input  WIDTH  instruction address
rs1_data  input  WIDTH  register-file read port 1
rs2_data  input  WIDTH  register-file read port 2
out_valid  output  1  buffered entry valid toward ALU/EX
out_ready  input  1  downstream consumes entry this cycle
alu_op1  output  WIDTH  ALU operand 1
alu_op2  output  WIDTH  ALU operand 2
alu_ctrl  output  4  ALU operation code
rd  output  5  destination register index
wb_en  output  1  result is to be written back
illegal  output  1  instruction not supported by this stage/ALU

Behaviour:
- ALU codes: 0000 add, 0001 sub, 0010 eq, 0011 ltu, 0100 lt(signed), 0101 and, 0110 or, 0111 xor, 1000 srl, 1001 sll, 1111 none (ALU outputs 0).
- Decode table (opcode/funct3/funct7):
  - OP 0110011: 000/0000000 add; 000/0100000 sub; 001/0000000 sll; 010 lt; 011 ltu; 100 xor; 101/0000000 srl; 110 or; 111 and. op1 = rs1_data, op2 = rs2_data.
  - OP-IMM 0010011: addi→add, slti→lt, sltiu→ltu, xori, ori, andi. op2 = sign-extended inst[31:20].
  - slli (001, inst[31:25]=0) →sll; srli (101, inst[31:25]=0) →srl. op2 = zero-extended inst[24:20].
  - LUI 0110111: op1 = 0, op2 = {inst[31:12], 12'b0}, add.
  - AUIPC 0010111: op1 = pc, op2 = U-imm, add.
- Shift masking (sll/srl, both OP and OP-IMM): op2 is forced to {27'b0, op2[4:0]}. Required because the ALU shifts by the full operand.
- Illegal: any other encoding, including sra/srai (funct7 0100000 with funct3 101), bad funct7, and non-ALU opcodes.
  - Outputs for an illegal entry: illegal = 1, wb_en = 0, alu_ctrl = 1111, op1 = op2 = 0.
  - Illegal entries still pass through the handshake normally.
- wb_en = 1 for legal instructions whose rd != 0; wb_en = 0 when rd = 0. rd = inst[11:7] always.
- in_ready = !flush && (!out_valid || out_ready). This is combinational; no combinational path from in_valid to in_ready.
- Accept: when in_valid && in_ready, the decoded entry is loaded on the next edge and out_valid = 1. Latency is 1 cycle.
- Hold: while out_valid && !out_ready, all outputs stay bit-stable.
- Simultaneous consume + accept (out_valid, out_ready, in_valid all 1): the new entry replaces the old one; out_valid stays 1 with no bubble.
- Consume without a new input: out_valid goes to 0 next cycle. Data outputs keep their last values (don't-care).
- Flush: next cycle out_valid = 0. Any same-cycle input is dropped, since in_ready = 0 during flush.
- Priority: rst > flush > transfer.
- Reset: out_valid = 0, alu_op1 = alu_op2 = 0, alu_ctrl = 0000, rd = 0, wb_en = 0, illegal = 0. Reset asserted mid-stall discards the entry.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1 = 5, rs2 = 7, out_ready = 1 -> one cycle later out_valid = 1, op1 = 5, op2 = 7, ctrl = 0000, rd = 3, wb_en = 1, illegal = 0.
- SLL x5,x6,x7 (0x007312B3), rs2 = 0x00000023 -> op2 = 0x00000003, ctrl = 1001. ADDI x1,x0,-1 (0xFFF00093) -> op2 = 0xFFFFFFFF, ctrl = 0000.
- LUI x1,0x12345 (0x123450B7) -> op1 = 0, op2 = 0x12345000, ctrl = 0000. AUIPC with pc = 0x100 and the same imm -> op1 = 0x100.
- SRAI x1,x1,1 (0x4010D093) -> illegal = 1, wb_en = 0, ctrl = 1111, out_valid = 1.
- Backpressure: hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, outputs stable. Release -> back-to-back transfers, one per cycle, no bubble.
- Flush while out_valid = 1 and in_valid = 1 -> out_valid = 0 next cycle, input not accepted. rst asserted mid-stall -> all outputs at reset values next cycle.
